// File: rtl/pc_sequencer_if.sv
// +----------------------------------------------------------------------+
// | pc_sequencer_if : instruction-memory fetch handshake bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------+
// | pc_sequencer : fetch/execute program-counter sequencer with halt     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        run,
  input  wire logic        clear,
  pc_sequencer_if.master   imem,
  output logic [15:0]      instr,
  output logic             instr_valid,
  input  wire logic        exec_done,
  input  wire logic        zr,
  input  wire logic        ng,
  input  wire logic [15:0] jump_target,
  output logic [15:0]      pc,
  output logic             halted
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_exec  = 2'd2;
  localparam logic [1:0] c_halt  = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic        r_instr_valid;

  logic        w_take;
  logic        w_self_jump;
  logic [15:0] w_next_pc;

  // Jump condition bits j2/j1/j0 select the ng / zr / positive outcomes.
  assign w_take = r_instr[15] &
                  ((r_instr[2] & ng) |
                   (r_instr[1] & zr) |
                   (r_instr[0] & ~ng & ~zr));

  assign w_next_pc   = w_take ? jump_target : (r_pc + 16'd1);
  assign w_self_jump = w_take && (jump_target == r_pc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= c_idle;
      r_pc          <= RESET_PC;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      if (clear) begin
        r_state <= c_idle;
        r_pc    <= RESET_PC;
      end else begin
        case (r_state)
          c_idle: begin
            if (run) r_state <= c_fetch;
          end
          c_fetch: begin
            if (imem.imem_ack) begin
              r_instr       <= imem.imem_data;
              r_instr_valid <= 1'b1;
              r_state       <= c_exec;
            end
          end
          c_exec: begin
            if (exec_done) begin
              r_pc <= w_next_pc;
              if (w_self_jump)
                r_state <= c_halt;
              else if (run)
                r_state <= c_fetch;
              else
                r_state <= c_idle;
            end
          end
          default: r_state <= c_halt;
        endcase
      end
    end
  end

  assign imem.imem_req  = (r_state == c_fetch);
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc             = r_pc;
  assign halted         = (r_state == c_halt);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: fetched words are queued on ack and
// popped when instr_valid pulses; pc/handshake checked inline per scenario.
`default_nettype none

module tb_pc_sequencer;
  localparam logic [15:0] c_reset_pc = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic [15:0] pc;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_q[$];

  pc_sequencer_if imem ();

  pc_sequencer #(.RESET_PC(c_reset_pc)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .clear       (clear),
    .imem        (imem.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .zr          (zr),
    .ng          (ng),
    .jump_target (jump_target),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  initial begin
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'h0000;
  end

  // Scoreboard: every instr_valid pulse must match the oldest acked word.
  always @(negedge clock) begin
    if (reset === 1'b1 && instr_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_extra_valid instr=%h with empty queue", instr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (instr !== e) begin
          tests_failed++;
          $display("FAIL scoreboard_instr got=%h exp=%h", instr, e);
        end
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (imem.imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_req timeout imem_req=%b exp=1", imem.imem_req);
    end
  endtask

  task automatic do_instr(input logic [15:0] d, input logic z, input logic n,
                          input logic [15:0] jt);
    wait_req();
    imem.imem_ack  = 1'b1;
    imem.imem_data = d;
    exp_q.push_back(d);
    @(negedge clock);
    imem.imem_ack  = 1'b0;
    imem.imem_data = 16'hDEAD;
    exec_done   = 1'b1;
    zr          = z;
    ng          = n;
    jump_target = jt;
    @(negedge clock);
    exec_done = 1'b0;
    zr = 1'b0;
    ng = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if (pc !== c_reset_pc || instr !== 16'h0000 || instr_valid !== 1'b0 ||
        imem.imem_req !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values pc=%h instr=%h v=%b req=%b h=%b exp 0000 0000 0 0 0",
               pc, instr, instr_valid, imem.imem_req, halted);
    end
    run = 1'b1;
    @(negedge clock);
    @(negedge clock);
    tests_run++;
    if (imem.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold req=%b exp=0", imem.imem_req);
    end
    run = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sequential();
    run = 1'b1;
    @(negedge clock);
    tests_run++;
    if (imem.imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_to_fetch_latency req=%b exp=1", imem.imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (imem.imem_addr !== 16'(i)) begin
        tests_failed++;
        $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem.imem_addr, 16'(i));
      end
      // zero-wait ack: instr_valid must appear on the very next cycle
      imem.imem_ack = 1'b1;
      imem.imem_data = 16'h0005;
      exp_q.push_back(16'h0005);
      @(negedge clock);
      imem.imem_ack = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_valid[%0d] valid=%b req=%b exp 1 0", i, instr_valid, imem.imem_req);
      end
      exec_done = 1'b1;
      @(negedge clock);
      exec_done = 1'b0;
      tests_run++;
      if (pc !== 16'(i + 1) || imem.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_pc[%0d] pc=%h req=%b valid=%b exp %h 1 0",
                 i, pc, imem.imem_req, instr_valid, 16'(i + 1));
      end
    end
  endtask

  task automatic test_jumps();
    logic [15:0] p;
    do_instr(16'hE302, 1'b1, 1'b0, 16'h0040);
    tests_run++;
    if (pc !== 16'h0040 || imem.imem_addr !== 16'h0040) begin
      tests_failed++;
      $display("FAIL jump_taken pc=%h addr=%h exp 0040 0040", pc, imem.imem_addr);
    end
    p = pc;
    do_instr(16'hE301, 1'b0, 1'b1, 16'h0100);
    tests_run++;
    if (pc !== p + 16'd1) begin
      tests_failed++;
      $display("FAIL jump_not_taken pc=%h exp=%h", pc, p + 16'd1);
    end
  endtask

  task automatic test_wrap();
    do_instr(16'hE307, 1'b0, 1'b0, 16'hFFFF);
    tests_run++;
    if (pc !== 16'hFFFF || imem.imem_addr !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_setup pc=%h addr=%h exp FFFF FFFF", pc, imem.imem_addr);
    end
    do_instr(16'h0005, 1'b0, 1'b0, 16'h1234);
    tests_run++;
    if (pc !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap pc=%h exp=0000", pc);
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] a0;
    wait_req();
    a0 = imem.imem_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== a0) begin
        tests_failed++;
        $display("FAIL wait_state[%0d] req=%b addr=%h exp 1 %h", i, imem.imem_req, imem.imem_addr, a0);
      end
    end
    do_instr(16'h0007, 1'b0, 1'b0, 16'h0000);
    tests_run++;
    if (pc !== a0 + 16'd1) begin
      tests_failed++;
      $display("FAIL wait_state_pc pc=%h exp=%h", pc, a0 + 16'd1);
    end
  endtask

  task automatic test_clear_priority();
    wait_req();
    imem.imem_ack = 1'b1;
    imem.imem_data = 16'h0009;
    exp_q.push_back(16'h0009);
    @(negedge clock);
    imem.imem_ack = 1'b0;
    exec_done = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    exec_done = 1'b0;
    clear = 1'b0;
    tests_run++;
    if (pc !== c_reset_pc || imem.imem_req !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_priority pc=%h req=%b h=%b exp %h 0 0", pc, imem.imem_req, halted, c_reset_pc);
    end
  endtask

  task automatic test_halt();
    do_instr(16'hE307, 1'b0, 1'b0, 16'h0010);
    do_instr(16'hEA87, 1'b0, 1'b0, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (halted !== 1'b1 || imem.imem_req !== 1'b0 || pc !== 16'h0010 || instr !== 16'hEA87) begin
        tests_failed++;
        $display("FAIL halt[%0d] h=%b req=%b pc=%h instr=%h exp 1 0 0010 EA87",
                 i, halted, imem.imem_req, pc, instr);
      end
      imem.imem_ack = 1'b1;
      @(negedge clock);
      imem.imem_ack = 1'b0;
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || pc !== c_reset_pc || imem.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_clear h=%b pc=%h req=%b exp 0 %h 0", halted, pc, imem.imem_req, c_reset_pc);
    end
  endtask

  task automatic test_run_drop();
    logic [15:0] p;
    wait_req();
    p = pc;
    imem.imem_ack = 1'b1;
    imem.imem_data = 16'h0011;
    exp_q.push_back(16'h0011);
    @(negedge clock);
    imem.imem_ack = 1'b0;
    run = 1'b0;
    @(negedge clock);
    exec_done = 1'b1;
    @(negedge clock);
    exec_done = 1'b0;
    tests_run++;
    if (pc !== p + 16'd1) begin
      tests_failed++;
      $display("FAIL run_drop_pc pc=%h exp=%h", pc, p + 16'd1);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (imem.imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL run_drop_idle[%0d] req=%b exp=0", i, imem.imem_req);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_exec();
    run = 1'b1;
    wait_req();
    imem.imem_ack = 1'b1;
    imem.imem_data = 16'hE307;
    exp_q.push_back(16'hE307);
    @(negedge clock);
    imem.imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (pc !== c_reset_pc || instr !== 16'h0000 || instr_valid !== 1'b0 ||
        imem.imem_req !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async pc=%h instr=%h v=%b req=%b h=%b exp %h 0000 0 0 0",
               pc, instr, instr_valid, imem.imem_req, halted, c_reset_pc);
    end
    @(negedge clock);
    reset = 1'b1;
    tests_run++;
    if (imem.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle req=%b exp=0", imem.imem_req);
    end
    @(negedge clock);
    tests_run++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== c_reset_pc) begin
      tests_failed++;
      $display("FAIL reset_restart req=%b addr=%h exp 1 %h", imem.imem_req, imem.imem_addr, c_reset_pc);
    end
    run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jumps();
    test_wrap();
    test_wait_states();
    test_clear_priority();
    test_halt();
    test_run_drop();
    test_reset_mid_exec();
    @(negedge clock);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, the PC value loaded on reset and on clear.
REQ-002 Port: clock, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset.
REQ-004 Port: run, input, 1, permission to start or continue fetching.
REQ-005 Port: clear, input, 1, synchronous restart.
REQ-006 Port: imem_req, output, 1, instruction-memory request.
REQ-007 Port: imem_addr, output, 16, fetch address; equals pc.
REQ-008 Port: imem_ack, input, 1, memory reports data valid this cycle.
REQ-009 Port: imem_data, input, 16, fetched instruction word.
REQ-010 Port: instr, output, 16, latched current instruction.
REQ-011 Port: instr_valid, output, 1, one-cycle pulse when instr is updated.
REQ-012 Port: exec_done, input, 1, the execute stage has finished the current instruction.
REQ-013 Port: zr, input, 1, ALU result is zero; sampled with exec_done.
REQ-014 Port: ng, input, 1, ALU result is negative; sampled with exec_done.
REQ-015 Port: jump_target, input, 16, branch target (A register); sampled with exec_done.
REQ-016 Port: pc, output, 16, program counter.
REQ-017 Port: halted, output, 1, high while in HALT.

Function
REQ-018 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALT, held in a registered state.
REQ-019 imem_req SHALL be 1 exactly when the state is FETCH, decoded from the registered state.
REQ-020 IDLE: pc is held; when run=1 the FSM moves to FETCH on the next edge.
REQ-021 FETCH: the request is held until imem_ack=1.
REQ-022 On the FETCH edge with imem_ack=1, the block SHALL latch imem_data into instr, pulse instr_valid for exactly one cycle and move to EXEC.
REQ-023 EXEC: the block waits for exec_done=1. A request is never issued in EXEC, and imem_ack outside FETCH is ignored.
REQ-024 The jump is taken iff instr[15]=1 and (instr[2]&ng | instr[1]&zr | instr[0]&~ng&~zr).
REQ-025 On exec_done in EXEC, pc SHALL become jump_target if the jump is taken, else pc+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-026 Same edge as REQ-025: if the jump is taken and jump_target equals the current pc, the FSM SHALL go to HALT.
REQ-027 Otherwise on that edge the FSM goes to FETCH if run=1, else to IDLE.
REQ-028 HALT: pc and instr are frozen and halted=1; HALT is left only by clear or reset.
REQ-029 clear=1 in any state SHALL set pc=RESET_PC, state=IDLE and instr_valid=0 on the next edge.
REQ-030 When clear=1 coincides with imem_ack, exec_done or HALT entry, clear SHALL take priority.
REQ-031 Deasserting run during FETCH or EXEC SHALL NOT abort; the current instruction completes and then the FSM goes to IDLE.
REQ-032 Latency SHALL be: IDLE with run -> FETCH in 1 cycle; ack -> instr_valid in 1 cycle; exec_done -> new pc and new imem_req in 1 cycle.
REQ-033 A zero-wait memory (imem_ack high in the first FETCH cycle) SHALL yield instr_valid on the next cycle.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0 and halted=0, independent of clock.
REQ-035 Reset asserted mid-FETCH or mid-EXEC SHALL discard the pending transaction; after release the FSM starts from IDLE.
REQ-036 Reset release SHALL be synchronous to clock; the first transition out of IDLE is no earlier than the first edge after release.

Verification
REQ-037 Sequential: run=1, ack each FETCH, instr=16'h0005 (A-instruction), exec_done each EXEC -> pc steps 0,1,2,3 with one instr_valid pulse per fetch.
REQ-038 Taken jump: instr=16'hE302, zr=1, jump_target=16'h0040, exec_done -> pc=16'h0040, next imem_addr=16'h0040.
REQ-039 Not-taken jump: instr=16'hE301, ng=1 -> pc=pc+1.
REQ-040 Wrap: pc=16'hFFFF, A-instruction, exec_done -> pc=16'h0000.
REQ-041 Halt: pc=16'h0010, instr=16'hEA87, jump_target=16'h0010, exec_done -> halted=1, imem_req=0 and pc stays 16'h0010; clear -> pc=RESET_PC, IDLE.
REQ-042 Ack held low 5 cycles -> imem_req=1 and imem_addr stable for all 5 cycles.
REQ-043 reset pulse during EXEC -> all outputs take reset values immediately.
REQ-044 run dropped during EXEC -> IDLE after exec_done, pc incremented, no further imem_req.
